// File: rtl/reg_file_syscall_pkg.sv
// Shared constants for the MIPS register file and its syscall-side state.
package reg_file_syscall_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [ADDR_W-1:0] REG_V0   = 5'd2;
  localparam logic [ADDR_W-1:0] REG_A0   = 5'd4;
  localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

  localparam logic [DATA_W-1:0] DISP_CODE_DEFAULT = 32'h0000_0022;

endpackage

// File: rtl/reg_file_syscall_monitor.sv
// Syscall monitor: display latch, pause decode and saturating pause-cycle counter.
module reg_file_syscall_monitor
  import reg_file_syscall_pkg::*;
#(
  parameter logic [DATA_W-1:0] DISP_CODE = DISP_CODE_DEFAULT,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              syscall,
  input  logic              go,
  input  logic [DATA_W-1:0] r1_out,
  input  logic [DATA_W-1:0] r2_out,
  output logic [DATA_W-1:0] led_data,
  output logic [CNT_W-1:0]  pause_cnt
);

  logic [DATA_W-1:0] led_q, led_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              disp_hit;
  logic              paused;

  // Must match the PC-enable logic exactly: a display syscall never pauses.
  assign disp_hit = syscall && (r1_out == DISP_CODE);
  assign paused   = syscall && (r1_out != DISP_CODE) && !go;

  always_comb begin
    led_d = led_q;
    cnt_d = cnt_q;
    if (disp_hit) begin
      led_d = r2_out;
    end
    if (paused && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q <= '0;
      cnt_q <= '0;
    end else begin
      led_q <= led_d;
      cnt_q <= cnt_d;
    end
  end

  assign led_data  = led_q;
  assign pause_cnt = cnt_q;

endmodule

// File: rtl/reg_file_syscall.sv
// 32x32 MIPS general register file with syscall display latch and pause counter.
module reg_file_syscall
  import reg_file_syscall_pkg::*;
#(
  parameter logic [DATA_W-1:0] DISP_CODE = DISP_CODE_DEFAULT,
  parameter int unsigned       CNT_W     = 16,
  parameter bit                DBG_EN    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [ADDR_W-1:0] r2_addr,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] din,
  input  logic              syscall,
  input  logic              go,
  output logic [DATA_W-1:0] r1_out,
  output logic [DATA_W-1:0] r2_out,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [DATA_W-1:0] led_data,
  output logic [CNT_W-1:0]  pause_cnt
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  // Writes to address 0 are dropped; that covers $zero and the upstream error code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we && (w_addr != REG_ZERO)) begin
      regs_q[w_addr] <= din;
    end
  end

  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] addr);
    return (addr == REG_ZERO) ? '0 : regs_q[addr];
  endfunction

  // No write bypass: same-cycle reads see the pre-edge value.
  assign r1_out = rd(r1_addr);
  assign r2_out = rd(r2_addr);

  if (DBG_EN) begin : g_dbg
    assign dbg_data = rd(dbg_addr);
  end else begin : g_no_dbg
    assign dbg_data = '0;
  end

  reg_file_syscall_monitor #(
    .DISP_CODE (DISP_CODE),
    .CNT_W     (CNT_W)
  ) u_syscall_monitor (
    .clk       (clk),
    .rst       (rst),
    .syscall   (syscall),
    .go        (go),
    .r1_out    (r1_out),
    .r2_out    (r2_out),
    .led_data  (led_data),
    .pause_cnt (pause_cnt)
  );

endmodule

// File: tb/tb_reg_file_syscall.sv
// Directed scoreboard bench for reg_file_syscall with a 4-bit pause counter.
module tb_reg_file_syscall;
  import reg_file_syscall_pkg::*;

  localparam int unsigned CNT_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              we;
  logic [ADDR_W-1:0] r1_addr, r2_addr, w_addr, dbg_addr;
  logic [DATA_W-1:0] din;
  logic              syscall, go;
  logic [DATA_W-1:0] r1_out, r2_out, dbg_data, led_data;
  logic [CNT_W-1:0]  pause_cnt;

  typedef enum logic [2:0] {SelR1, SelR2, SelDbg, SelLed, SelCnt} sel_e;
  typedef struct {
    string       tag;
    sel_e        sel;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model [NUM_REGS];
  int          total_cnt = 0;
  int          pass_cnt  = 0;
  int          fail_cnt  = 0;

  reg_file_syscall #(
    .DISP_CODE (32'h0000_0022),
    .CNT_W     (CNT_W),
    .DBG_EN    (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .r1_addr   (r1_addr),
    .r2_addr   (r2_addr),
    .w_addr    (w_addr),
    .din       (din),
    .syscall   (syscall),
    .go        (go),
    .r1_out    (r1_out),
    .r2_out    (r2_out),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .led_data  (led_data),
    .pause_cnt (pause_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] observe(input sel_e sel);
    case (sel)
      SelR1:   return r1_out;
      SelR2:   return r2_out;
      SelDbg:  return dbg_data;
      SelLed:  return led_data;
      default: return {{(32 - CNT_W){1'b0}}, pause_cnt};
    endcase
  endfunction

  task automatic push(input string tag, input sel_e sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    #1;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      obs = observe(e.sel);
      total_cnt++;
      assert (obs === e.exp) pass_cnt++;
      else begin
        fail_cnt++;
        $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    we     = 1'b1;
    w_addr = addr;
    din    = data;
    tick();
    we = 1'b0;
    if (addr != 5'd0) model[addr] = data;
  endtask

  task automatic check_all_dbg(input string tag);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      push($sformatf("%s_dbg[%0d]", tag, i), SelDbg, model[i]);
      drain();
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    rst = 1'b1; we = 1'b0; r1_addr = '0; r2_addr = '0; w_addr = '0; dbg_addr = '0;
    din = '0; syscall = 1'b0; go = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state on all three read ports.
    for (int i = 0; i < 32; i++) begin
      r1_addr  = 5'(i);
      r2_addr  = 5'(i);
      dbg_addr = 5'(i);
      push($sformatf("rst_r1[%0d]", i), SelR1, 32'h0);
      push($sformatf("rst_r2[%0d]", i), SelR2, 32'h0);
      push($sformatf("rst_dbg[%0d]", i), SelDbg, 32'h0);
      drain();
    end
    push("rst_led", SelLed, 32'h0);
    push("rst_cnt", SelCnt, 32'h0);
    drain();

    // Read-during-write returns the old value; new value after the edge.
    we = 1'b1; w_addr = 5'd5; din = 32'hDEAD_BEEF; r1_addr = 5'd5;
    push("rdw_old", SelR1, 32'h0);
    drain();
    tick();
    we = 1'b0;
    model[5] = 32'hDEAD_BEEF;
    push("wr_new", SelR1, 32'hDEAD_BEEF);
    drain();

    // Writes to address 0 are dropped.
    wr(5'd0, 32'h1234_5678);
    r1_addr = 5'd0;
    r2_addr = 5'd5;
    push("zero_r1", SelR1, 32'h0);
    push("zero_r2_keep", SelR2, 32'hDEAD_BEEF);
    drain();
    check_all_dbg("after_zero");

    wr(REG_RA, 32'hCAFE_0001);
    r2_addr = REG_RA;
    push("ra_r2", SelR2, 32'hCAFE_0001);
    drain();

    // Display syscall.
    wr(REG_V0, 32'h0000_0022);
    wr(REG_A0, 32'h0000_0ABC);
    syscall = 1'b1; go = 1'b0; r1_addr = REG_V0; r2_addr = REG_A0;
    push("disp_v0", SelR1, 32'h22);
    drain();
    tick();
    syscall = 1'b0;
    push("disp_led", SelLed, 32'h0000_0ABC);
    push("disp_cnt", SelCnt, 32'h0);
    drain();

    // Non-display syscall: 7 paused cycles, then go releases it.
    wr(REG_V0, 32'h0000_000A);
    syscall = 1'b1; go = 1'b0;
    repeat (7) tick();
    go = 1'b1;
    tick();
    syscall = 1'b0; go = 1'b0;
    push("pause7_cnt", SelCnt, 32'd7);
    push("pause7_led", SelLed, 32'h0000_0ABC);
    drain();

    // Saturation: 7 + 20 exceeds 4'hF.
    syscall = 1'b1;
    repeat (20) tick();
    push("sat_cnt", SelCnt, 32'hF);
    drain();

    // Asynchronous reset between edges, mid-pause.
    #2;
    rst = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    push("arst_r1", SelR1, 32'h0);
    push("arst_r2", SelR2, 32'h0);
    push("arst_led", SelLed, 32'h0);
    push("arst_cnt", SelCnt, 32'h0);
    drain();
    check_all_dbg("arst");
    tick();
    rst = 1'b0;
    // $v0 now reads 0, so the still-pending syscall pauses again.
    tick();
    push("repause_cnt", SelCnt, 32'd1);
    drain();
    syscall = 1'b0;

    // Display syscall with go=1 and with we=1 in the same cycle.
    wr(REG_V0, 32'h0000_0022);
    wr(REG_A0, 32'h0000_0055);
    syscall = 1'b1; go = 1'b1; we = 1'b1; w_addr = 5'd9; din = 32'h0BAD_F00D;
    tick();
    syscall = 1'b0; go = 1'b0; we = 1'b0;
    model[9] = 32'h0BAD_F00D;
    dbg_addr = 5'd9;
    push("disp_go_led", SelLed, 32'h0000_0055);
    push("disp_go_cnt", SelCnt, 32'd1);
    push("we_sys_dbg", SelDbg, 32'h0BAD_F00D);
    drain();

    // Syscall with go=1 but not a display code: no count.
    wr(REG_V0, 32'h0000_0001);
    syscall = 1'b1; go = 1'b1;
    tick();
    syscall = 1'b0; go = 1'b0;
    push("go_nocount", SelCnt, 32'd1);
    push("go_led_hold", SelLed, 32'h0000_0055);
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
